mpsk_modulator: RTL and testbench

MPSK_MODULATOR -- requirements
Module: mpsk_modulator

---
 rtl/mpsk_pkg.sv | 62 ++++++
 rtl/mpsk_sym_strobe.sv | 25 ++
 rtl/mpsk_modulator.sv | 136 +++++++++++++
 tb/tb_mpsk_modulator.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpsk_pkg.sv
// mpsk_pkg -- shared definitions for the M-PSK modulator.
//   MODE encodings, FSM state enum, bits-per-symbol helper, symbol-to-phase
//   mapping and the 8-point cos/sin constellation LUT (scaled by amp).
package mpsk_pkg;

  localparam logic [1:0] MODE_BPSK = 2'd0;
  localparam logic [1:0] MODE_QPSK = 2'd1;
  localparam logic [1:0] MODE_8PSK = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;  // behaves as QPSK

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  function automatic logic [1:0] mode_bps(input logic [1:0] mode);
    case (mode)
      MODE_BPSK: return 2'd1;
      MODE_8PSK: return 2'd3;
      default:   return 2'd2;
    endcase
  endfunction

  // s is right-justified in bps bits
  function automatic logic [2:0] sym_phase(input logic [1:0] mode, input logic [2:0] s);
    case (mode)
      MODE_BPSK: return {s[0], 2'b00};
      MODE_8PSK: return {s[2], s[2] ^ s[1], s[2] ^ s[1] ^ s[0]};  // gray -> binary
      default: begin
        case (s[1:0])
          2'b00:   return 3'd1;
          2'b01:   return 3'd3;
          2'b11:   return 3'd5;
          default: return 3'd7;
        endcase
      end
    endcase
  endfunction

  // round(amp*cos(p*45deg)); 46341/65536 approximates 1/sqrt(2)
  function automatic int psk_cos(input logic [2:0] p, input int amp);
    int r;
    r = int'((longint'(amp) * 64'sd46341 + 64'sd32768) >>> 16);
    case (p)
      3'd0:    return amp;
      3'd1:    return r;
      3'd2:    return 0;
      3'd3:    return -r;
      3'd4:    return -amp;
      3'd5:    return -r;
      3'd6:    return 0;
      default: return r;
    endcase
  endfunction

  // sin(x) = cos(x - 90deg)
  function automatic int psk_sin(input logic [2:0] p, input int amp);
    return psk_cos(p + 3'd6, amp);
  endfunction

endpackage

// File: rtl/mpsk_sym_strobe.sv
// mpsk_sym_strobe -- free-running symbol-period counter 0..SYM_DIV-1.
//   clk, rst      : clock, synchronous active-high reset
//   delay_cnt     : counter value at which the strobe fires
//   sym_stb       : one-cycle pulse per symbol period
module mpsk_sym_strobe #(
  parameter int SYM_DIV = 16,
  localparam int CW = $clog2(SYM_DIV)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] delay_cnt,
  output logic          sym_stb
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                          cnt <= '0;
    else if (cnt == CW'(SYM_DIV - 1)) cnt <= '0;
    else                              cnt <= cnt + CW'(1);
  end

  assign sym_stb = (cnt == delay_cnt);

endmodule

// File: rtl/mpsk_modulator.sv
// mpsk_modulator -- byte-stream to BPSK/QPSK/8PSK I/Q sample generator.
//   clk_16d384M, rst_16d384M : clock, synchronous active-high reset
//   psk_t*                    : AXI-stream-like byte input (tuser = frame start)
//   MODE, DELAY_CNT, TX_PHASE_CONFIG : modulation, strobe phase, rotation
//   DAC_I/DAC_Q/DAC_valid/DAC_bits  : sample held for one symbol period
//   underflow                 : sticky, set when a symbol is due but data is short
// Optional: define MPSK_DIFF_ENC_EN for differential phase encoding.
module mpsk_modulator
  import mpsk_pkg::*;
#(
  parameter int DAC_W   = 12,
  parameter int SYM_DIV = 16,
  parameter int AMP     = 2047
) (
  input  logic                         clk_16d384M,
  input  logic                         rst_16d384M,
  input  logic [7:0]                   psk_tdata,
  input  logic                         psk_tvalid,
  input  logic                         psk_tlast,
  input  logic                         psk_tuser,
  output logic                         psk_tready,
  input  logic [1:0]                   MODE,
  input  logic [$clog2(SYM_DIV)-1:0]   DELAY_CNT,
  input  logic [2:0]                   TX_PHASE_CONFIG,
  output logic signed [DAC_W-1:0]      DAC_I,
  output logic signed [DAC_W-1:0]      DAC_Q,
  output logic                         DAC_valid,
  output logic [2:0]                   DAC_bits,
  output logic                         underflow
);

  state_e      state;
  logic [15:0] bit_buf, buf_n;  // MSB-justified; bits below bit_cnt are zero
  logic [4:0]  bit_cnt, cnt_n, bps5;
  logic [1:0]  mode_q, bps;
  logic        sym_stb, accept, frame_start, emit, starve, drain;
  logic [2:0]  sym, p_sym, p_tx, p_rot;
  logic signed [DAC_W-1:0] lut_i, lut_q;

  mpsk_sym_strobe #(.SYM_DIV(SYM_DIV)) u_sym_strobe (
    .clk       (clk_16d384M),
    .rst       (rst_16d384M),
    .delay_cnt (DELAY_CNT),
    .sym_stb   (sym_stb)
  );

  // held low while reset is asserted, high from the first cycle after
  assign psk_tready  = !rst_16d384M && (bit_cnt <= 5'd8) && (state != ST_FLUSH);
  assign accept      = psk_tvalid && psk_tready;
  assign frame_start = accept && ((state == ST_IDLE) || psk_tuser);

  assign bps  = mode_bps(mode_q);
  assign bps5 = {3'b000, bps};

  // FLUSH may emit a short symbol; the zero fill below bit_cnt pads it
  assign emit   = sym_stb && (state != ST_IDLE) &&
                  ((bit_cnt >= bps5) || ((state == ST_FLUSH) && (bit_cnt != 5'd0)));
  assign starve = sym_stb && (state == ST_RUN) && (bit_cnt < bps5);
  assign drain  = sym_stb && (state == ST_FLUSH) && (bit_cnt == 5'd0);

  assign sym   = bit_buf[15:13] >> (2'd3 - bps);
  assign p_sym = sym_phase(mode_q, sym);

`ifdef MPSK_DIFF_ENC_EN
  logic [2:0] ref_q;
  assign p_tx = ref_q + p_sym;
  always_ff @(posedge clk_16d384M) begin
    if (rst_16d384M)      ref_q <= '0;
    else if (frame_start) ref_q <= '0;
    else if (emit)        ref_q <= p_tx;
  end
`else
  assign p_tx = p_sym;
`endif

  assign p_rot = p_tx + TX_PHASE_CONFIG;
  assign lut_i = DAC_W'(psk_cos(p_rot, AMP));
  assign lut_q = DAC_W'(psk_sin(p_rot, AMP));

  // removal first, then append below what is left; a frame start discards all
  always_comb begin
    buf_n = bit_buf;
    cnt_n = bit_cnt;
    if (emit) begin
      buf_n = bit_buf << bps;
      cnt_n = (bit_cnt >= bps5) ? bit_cnt - bps5 : 5'd0;
    end
    if (frame_start) begin
      buf_n = {psk_tdata, 8'h00};
      cnt_n = 5'd8;
    end else if (accept) begin
      buf_n = buf_n | ({psk_tdata, 8'h00} >> cnt_n);
      cnt_n = cnt_n + 5'd8;
    end
  end

  always_ff @(posedge clk_16d384M) begin
    if (rst_16d384M) begin
      state     <= ST_IDLE;
      bit_buf   <= '0;
      bit_cnt   <= '0;
      mode_q    <= MODE_BPSK;
      DAC_I     <= '0;
      DAC_Q     <= '0;
      DAC_valid <= 1'b0;
      DAC_bits  <= '0;
      underflow <= 1'b0;
    end else begin
      bit_buf <= buf_n;
      bit_cnt <= cnt_n;
      if (state == ST_IDLE) mode_q <= MODE;

      case (state)
        ST_IDLE:  if (accept) state <= psk_tlast ? ST_FLUSH : ST_RUN;
        ST_RUN:   if (accept && psk_tlast) state <= ST_FLUSH;
        ST_FLUSH: if (drain) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase

      if (emit) begin
        DAC_I     <= lut_i;
        DAC_Q     <= lut_q;
        DAC_valid <= 1'b1;
        DAC_bits  <= sym;
      end else if (starve || drain) begin
        DAC_I     <= '0;
        DAC_Q     <= '0;
        DAC_valid <= 1'b0;
        DAC_bits  <= '0;
      end

      if (starve) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mpsk_modulator.sv
// tb_mpsk_modulator -- directed stimulus, queue-based reference model checked
// every cycle, plus literal constellation expectations.
module tb_mpsk_modulator;

  localparam int DAC_W = 12, SYM_DIV = 16, AMP = 2047;
  localparam real PI = 3.14159265358979;

  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] tdata = 8'h00;
  logic tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] dly = 4'd5;
  logic [2:0] txph = 3'd0;
  logic psk_tready, DAC_valid, underflow;
  logic signed [DAC_W-1:0] DAC_I, DAC_Q;
  logic [2:0] DAC_bits;

  always #5 clk = ~clk;

  mpsk_modulator #(.DAC_W(DAC_W), .SYM_DIV(SYM_DIV), .AMP(AMP)) dut (
    .clk_16d384M(clk), .rst_16d384M(rst),
    .psk_tdata(tdata), .psk_tvalid(tvalid), .psk_tlast(tlast), .psk_tuser(tuser),
    .psk_tready(psk_tready), .MODE(mode), .DELAY_CNT(dly), .TX_PHASE_CONFIG(txph),
    .DAC_I(DAC_I), .DAC_Q(DAC_Q), .DAC_valid(DAC_valid), .DAC_bits(DAC_bits),
    .underflow(underflow)
  );

  int total = 0, bad = 0;
  bit chk_en = 0;

  task automatic chk(string nm, logic signed [31:0] act, logic signed [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_RUN, M_FLUSH} mst_t;
  mst_t m_st = M_IDLE, nst_m;
  bit   mq[$];
  int   m_cyc = 0, m_mode = 0, m_ref = 0;
  int   e_i = 0, e_q = 0, e_bits = 0;
  bit   e_v = 0, e_uf = 0, upd = 0;
  bit   stb_m, rdy_m, acc_m;
  int   bps_m, s_m, p_m, pr_m;

  function automatic int n_bps(int m);
    return (m == 0) ? 1 : (m == 2) ? 3 : 2;
  endfunction

  function automatic int phase_of(int m, int s);
    int qmap[4];
    qmap = '{1, 3, 7, 5};
    if (m == 0) return 4 * s;
    if (m == 2) return s ^ (s >> 1) ^ (s >> 2);
    return qmap[s];
  endfunction

  function automatic int amp_cos(int p);
    return int'(AMP * $cos(p * PI / 4.0));
  endfunction

  function automatic int amp_sin(int p);
    return int'(AMP * $sin(p * PI / 4.0));
  endfunction

  always @(posedge clk) begin
    upd = 0;
    if (rst) begin
      mq.delete();
      m_st = M_IDLE; m_cyc = 0; m_ref = 0;
      e_i = 0; e_q = 0; e_bits = 0; e_v = 0; e_uf = 0;
    end else begin
      stb_m = ((m_cyc % SYM_DIV) == int'(dly));
      rdy_m = (mq.size() <= 8) && (m_st != M_FLUSH);
      acc_m = tvalid && rdy_m;
      bps_m = n_bps(m_mode);
      nst_m = m_st;
      if (stb_m && m_st != M_IDLE) begin
        upd = 1;
        if (mq.size() >= bps_m || (m_st == M_FLUSH && mq.size() > 0)) begin
          s_m = 0;
          repeat (bps_m) s_m = s_m * 2 + ((mq.size() > 0) ? int'(mq.pop_front()) : 0);
          p_m = phase_of(m_mode, s_m);
`ifdef MPSK_DIFF_ENC_EN
          p_m = (m_ref + p_m) % 8;
          m_ref = p_m;
`endif
          pr_m = (p_m + int'(txph)) % 8;
          e_i = amp_cos(pr_m); e_q = amp_sin(pr_m); e_v = 1; e_bits = s_m;
        end else begin
          e_i = 0; e_q = 0; e_v = 0; e_bits = 0;
          if (m_st == M_RUN) e_uf = 1;
          else nst_m = M_IDLE;
        end
      end
      if (m_st == M_IDLE) m_mode = int'(mode);
      if (acc_m) begin
        if (m_st == M_IDLE || tuser) begin mq.delete(); m_ref = 0; end
        for (int i = 7; i >= 0; i--) mq.push_back(tdata[i]);
        if (m_st == M_IDLE) nst_m = tlast ? M_FLUSH : M_RUN;
        else if (tlast) nst_m = M_FLUSH;
      end
      m_st = nst_m;
      m_cyc++;
    end
  end

  // per-cycle comparison of every output against the model
  always @(negedge clk) begin
    bit rq;
    if (chk_en) begin
      rq = !rst && (mq.size() <= 8) && (m_st != M_FLUSH);
      total++;
      if ($signed(DAC_I) !== e_i || $signed(DAC_Q) !== e_q || DAC_valid !== e_v ||
          DAC_bits !== e_bits[2:0] || underflow !== e_uf || psk_tready !== rq) begin
        bad++;
        $display("FAIL cycle t=%0t actual I=%0d Q=%0d v=%b bits=%0d uf=%b rdy=%b required I=%0d Q=%0d v=%b bits=%0d uf=%b rdy=%b",
                 $time, DAC_I, DAC_Q, DAC_valid, DAC_bits, underflow, psk_tready,
                 e_i, e_q, e_v, e_bits, e_uf, rq);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(posedge clk); #1 rst = 1; tvalid = 0; tlast = 0; tuser = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic send(logic [7:0] d, logic last, logic user);
    logic r;
    int n;
    n = 0;
    tdata = d; tlast = last; tuser = user; tvalid = 1;
    do begin
      @(negedge clk); r = psk_tready;
      @(posedge clk); n++;
    end while (!r && n < 200);
    #1 tvalid = 0; tlast = 0; tuser = 0;
    chk("send_accept", r, 1);
  endtask

  // wait for the next symbol-boundary update, then check the literal sample
  task automatic sym_is(string nm, int ei, int eq, int ev);
    bit seen;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk); seen = upd;
    end
    chk({nm, "_seen"}, seen, 1);
    chk({nm, "_i"}, DAC_I, ei);
    chk({nm, "_q"}, DAC_Q, eq);
    chk({nm, "_v"}, DAC_valid, ev);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int ibpsk[8];
    int found, want;
    ibpsk = '{-2047, 2047, -2047, 2047, 2047, -2047, 2047, -2047};

    // reset state
    repeat (3) @(posedge clk);
    #1 chk_en = 1;
    @(negedge clk);
    chk("rst_tready", psk_tready, 0);
    chk("rst_i", DAC_I, 0);
    chk("rst_q", DAC_Q, 0);
    chk("rst_valid", DAC_valid, 0);
    chk("rst_bits", DAC_bits, 0);
    chk("rst_uf", underflow, 0);
    @(posedge clk); #1 rst = 0;
    #1 chk("tready_after_rst", psk_tready, 1);

    // BPSK 0xA5
    mode = 2'd0; txph = 3'd0; dly = 4'd5;
    do_reset();
    send(8'hA5, 1, 0);
    sym_is("bpsk0", ibpsk[0], 0, 1);
    chk("bpsk0_bits", DAC_bits, 1);
    for (int k = 1; k < 8; k++) sym_is($sformatf("bpsk%0d", k), ibpsk[k], 0, 1);
    sym_is("bpsk_end", 0, 0, 0);

    // QPSK 0x1E, MODE change mid-frame must be ignored
    mode = 2'd1;
    do_reset();
    send(8'h1E, 1, 0);
    mode = 2'd0;
    sym_is("qpsk0", 1447, 1447, 1);
    sym_is("qpsk1", -1447, 1447, 1);
    sym_is("qpsk2", -1447, -1447, 1);
    sym_is("qpsk3", 1447, -1447, 1);
    chk("qpsk3_bits", DAC_bits, 2);
    sym_is("qpsk_end", 0, 0, 0);

    // QPSK rotated by 90 degrees
    mode = 2'd1; txph = 3'd2;
    do_reset();
    send(8'h1E, 1, 0);
    sym_is("qpsk_rot0", -1447, 1447, 1);
    txph = 3'd0;

    // 8PSK flush with padding
    mode = 2'd2;
    do_reset();
    send(8'hFF, 0, 0);
    send(8'hFF, 1, 0);
    for (int k = 0; k < 5; k++) sym_is($sformatf("8psk%0d", k), -1447, -1447, 1);
    sym_is("8psk_pad", 1447, -1447, 1);
    chk("8psk_pad_bits", DAC_bits, 4);
    sym_is("8psk_end", 0, 0, 0);
    chk("8psk_idle_tready", psk_tready, 1);

    // underflow
    mode = 2'd1;
    do_reset();
    send(8'h1E, 0, 0);
    sym_is("uf0", 1447, 1447, 1);
    sym_is("uf1", -1447, 1447, 1);
    sym_is("uf2", -1447, -1447, 1);
    sym_is("uf3", 1447, -1447, 1);
    sym_is("uf_starve", 0, 0, 0);
    chk("uf_flag", underflow, 1);
    chk("uf_tready", psk_tready, 1);

    // tuser restart discards the buffered 0xFF
    dly = 4'd8;
    do_reset();
    send(8'hFF, 0, 0);
    send(8'h00, 1, 1);
    for (int k = 0; k < 4; k++) sym_is($sformatf("restart%0d", k), 1447, 1447, 1);
    sym_is("restart_end", 0, 0, 0);

    // DELAY_CNT sweep: first valid sample cycle tracks the strobe phase
    mode = 2'd0;
    for (int d = 0; d < 16; d++) begin
      dly = 4'(d);
      do_reset();
      tdata = 8'h80; tlast = 1; tuser = 0; tvalid = 1;
      found = -1;
      for (int k = 0; k < 40 && found < 0; k++) begin
        @(negedge clk);
        if (DAC_valid === 1'b1) found = k;
        if (k == 0) begin @(posedge clk); #1 tvalid = 0; tlast = 0; end
      end
      want = (d == 0) ? 17 : d + 1;
      chk($sformatf("dly%0d_edge", d), found, want);
    end

    // reset during symbol 3, then a clean frame
    dly = 4'd5; mode = 2'd0;
    do_reset();
    send(8'hFF, 1, 0);
    sym_is("mid0", -2047, 0, 1);
    sym_is("mid1", -2047, 0, 1);
    sym_is("mid2", -2047, 0, 1);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1;
    chk("mid_rst_i", DAC_I, 0);
    chk("mid_rst_q", DAC_Q, 0);
    chk("mid_rst_v", DAC_valid, 0);
    chk("mid_rst_bits", DAC_bits, 0);
    chk("mid_rst_tready", psk_tready, 0);
    rst = 0;
    mode = 2'd1;
    send(8'h1E, 1, 0);
    sym_is("after_rst0", 1447, 1447, 1);
    sym_is("after_rst1", -1447, 1447, 1);
    repeat (80) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
